// File: rtl/riscv_pkg.sv
// Shared RV32I constants: data/register widths, load/store funct3 codes,
// LSU state encoding and the access-legality rule used at request time.
package riscv_pkg;

   localparam int unsigned RV_XLEN           = 32;
   localparam int unsigned RV_REG_ADDR_WIDTH = 5;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2
   } lsu_state_e;

   // Unsigned widths exist only for loads; halves need even, words need 4-byte alignment.
   function automatic logic lsu_access_ok(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] a);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~a[0];
         F3_W:    ok = (a == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane placement of store data and lane extraction / extension of load data.
module lsu_align
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = RV_XLEN
) (
   input  logic [2:0]      st_funct3,
   input  logic [1:0]      st_addr_lo,
   input  logic [XLEN-1:0] st_data,
   output logic [3:0]      st_be,
   output logic [XLEN-1:0] st_lane,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_addr_lo,
   input  logic [XLEN-1:0] ld_word,
   output logic [XLEN-1:0] ld_result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      st_be   = 4'b1111;
      st_lane = st_data;
      case (st_funct3[1:0])
         2'b00: begin
            st_be   = 4'b0001 << st_addr_lo;
            st_lane = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be   = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            st_lane = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel  = ld_word[{ld_addr_lo, 3'b000} +: 8];
      half_sel  = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
      ld_result = ld_word;
      case (ld_funct3)
         F3_B:    ld_result = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    ld_result = {{16{half_sel[15]}}, half_sel};
         F3_BU:   ld_result = {24'b0, byte_sel};
         F3_HU:   ld_result = {16'b0, half_sel};
         default: ld_result = ld_word;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one EXE access, runs the dmem req/gnt/rvalid handshake
// and returns a registered, extended load result to the MEM stage.
module lsu
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = RV_XLEN,
   parameter int unsigned RAW  = RV_REG_ADDR_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [RAW-1:0]  req_rd,
   output logic            stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            ld_valid,
   output logic [XLEN-1:0] ld_data,
   output logic [RAW-1:0]  ld_rd,
   output logic            err
);

   lsu_state_e      state_q;
   logic            dmem_req_q, dmem_we_q;
   logic [XLEN-1:0] dmem_addr_q, dmem_wdata_q;
   logic [3:0]      dmem_be_q;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic [RAW-1:0]  rd_q;
   logic            ld_valid_q, err_q;
   logic [XLEN-1:0] ld_data_q;
   logic [RAW-1:0]  ld_rd_q;

   logic            access_ok, accept;
   logic [3:0]      st_be;
   logic [XLEN-1:0] st_lane, ld_result;

   assign access_ok = lsu_access_ok(req_we, req_funct3, req_addr[1:0]);
   assign accept    = (state_q == LSU_IDLE) && req_valid && access_ok;

   lsu_align #(.XLEN(XLEN)) u_align (
      .st_funct3  (req_funct3),
      .st_addr_lo (req_addr[1:0]),
      .st_data    (req_wdata),
      .st_be      (st_be),
      .st_lane    (st_lane),
      .ld_funct3  (funct3_q),
      .ld_addr_lo (addr_lo_q),
      .ld_word    (dmem_rdata),
      .ld_result  (ld_result)
   );

   // Stall drops in the completing cycle so EXE can present the next access at once.
   always_comb begin
      stall = 1'b0;
      case (state_q)
         LSU_IDLE: stall = accept;
         LSU_REQ:  stall = ~(dmem_gnt & dmem_we_q);
         LSU_WAIT: stall = ~dmem_rvalid;
         default:  stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LSU_IDLE;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= '0;
         dmem_wdata_q <= '0;
         funct3_q     <= '0;
         addr_lo_q    <= '0;
         rd_q         <= '0;
         ld_valid_q   <= 1'b0;
         ld_data_q    <= '0;
         ld_rd_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q      <= (state_q == LSU_IDLE) && req_valid && !access_ok;
         ld_valid_q <= 1'b0;
         case (state_q)
            LSU_IDLE: begin
               if (accept) begin
                  state_q      <= LSU_REQ;
                  dmem_req_q   <= 1'b1;
                  dmem_we_q    <= req_we;
                  dmem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
                  dmem_be_q    <= req_we ? st_be : 4'b1111;
                  dmem_wdata_q <= req_we ? st_lane : '0;
                  funct3_q     <= req_funct3;
                  addr_lo_q    <= req_addr[1:0];
                  rd_q         <= req_rd;
               end
            end
            LSU_REQ: begin
               // rvalid arriving with gnt belongs to nothing we issued yet
               if (dmem_gnt) begin
                  dmem_req_q <= 1'b0;
                  state_q    <= dmem_we_q ? LSU_IDLE : LSU_WAIT;
               end
            end
            LSU_WAIT: begin
               if (dmem_rvalid) begin
                  state_q    <= LSU_IDLE;
                  ld_valid_q <= 1'b1;
                  ld_data_q  <= ld_result;
                  ld_rd_q    <= rd_q;
               end
            end
            default: state_q <= LSU_IDLE;
         endcase
      end
   end

   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_be    = dmem_be_q;
   assign dmem_wdata = dmem_wdata_q;
   assign ld_valid   = ld_valid_q;
   assign ld_data    = ld_data_q;
   assign ld_rd      = ld_rd_q;
   assign err        = err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: vector table of single accesses plus hand-written back-to-back
// and reset-in-WAIT sequences; load results are checked through a scoreboard queue.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        ld_valid, err;
   logic [31:0] ld_data;
   logic [4:0]  ld_rd;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned gw;
      logic        err;
      logic [3:0]  be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_ld;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
   } ld_exp_t;

   vec_t    vecs[15];
   ld_exp_t exp_q[$];

   lsu #(.XLEN(32), .RAW(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && ld_valid) begin
         if (exp_q.size() == 0) begin
            check("ld_spurious", {31'b0, ld_valid}, 32'd0);
         end else begin
            ld_exp_t e;
            e = exp_q.pop_front();
            check("ld_data", ld_data, e.data);
            check("ld_rd", {27'b0, ld_rd}, {27'b0, e.rd});
         end
      end
   end

   task automatic txn(input vec_t v, input logic [4:0] rd);
      @(negedge clk);
      req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      req_rd = rd; req_valid = 1'b1;
      #1;
      if (v.err) begin
         check("ill_stall", {31'b0, stall}, 32'd0);
         @(negedge clk);
         req_valid = 1'b0;
         #1;
         check("err_pulse", {31'b0, err}, 32'd1);
         check("ill_noreq", {31'b0, dmem_req}, 32'd0);
         @(negedge clk);
         check("err_clear", {31'b0, err}, 32'd0);
         check("ill_noreq2", {31'b0, dmem_req}, 32'd0);
      end else begin
         check("acc_stall", {31'b0, stall}, 32'd1);
         @(negedge clk);
         check("req_up", {31'b0, dmem_req}, 32'd1);
         check("req_we", {31'b0, dmem_we}, {31'b0, v.we});
         check("req_addr", dmem_addr, {v.addr[31:2], 2'b00});
         check("req_be", {28'b0, dmem_be}, {28'b0, v.be});
         if (v.we) check("req_wdata", dmem_wdata, v.exp_wdata);
         for (int unsigned i = 0; i < v.gw; i++) begin
            check("wait_stall", {31'b0, stall}, 32'd1);
            @(negedge clk);
            check("req_hold", {31'b0, dmem_req}, 32'd1);
            check("addr_hold", dmem_addr, {v.addr[31:2], 2'b00});
         end
         dmem_gnt = 1'b1;
         if (!v.we) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'hBAD0BAD0;
         end
         #1;
         check("gnt_stall", {31'b0, stall}, {31'b0, !v.we});
         @(negedge clk);
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
         if (v.we) begin
            req_valid = 1'b0;
            #1;
            check("st_done_req", {31'b0, dmem_req}, 32'd0);
            check("st_done_stall", {31'b0, stall}, 32'd0);
         end else begin
            check("wait_noreq", {31'b0, dmem_req}, 32'd0);
            dmem_gnt = 1'b1;
            #1;
            check("wait_stall", {31'b0, stall}, 32'd1);
            @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
            #1;
            check("rv_stall", {31'b0, stall}, 32'd0);
            exp_q.push_back('{v.exp_ld, rd});
            @(negedge clk);
            dmem_rvalid = 1'b0; req_valid = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          we    f3    addr          wdata         rdata         gw err be       exp_wdata     exp_ld
      vecs[0]  = '{1'b1, 3'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,        2, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
      vecs[2]  = '{1'b1, 3'd1, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
      vecs[3]  = '{1'b1, 3'd0, 32'h0000_1001, 32'h0000_0077, 32'h0,        0, 0, 4'b0010, 32'h7777_7777, 32'h0};
      vecs[4]  = '{1'b0, 3'd0, 32'h0000_2002, 32'h0,         32'h12F4_3456, 0, 0, 4'b1111, 32'h0,        32'hFFFF_FFF4};
      vecs[5]  = '{1'b0, 3'd4, 32'h0000_2002, 32'h0,         32'h12F4_3456, 1, 0, 4'b1111, 32'h0,        32'h0000_00F4};
      vecs[6]  = '{1'b0, 3'd1, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 0, 4'b1111, 32'h0,        32'hFFFF_8001};
      vecs[7]  = '{1'b0, 3'd5, 32'h0000_2000, 32'h0,         32'h8001_9234, 2, 0, 4'b1111, 32'h0,        32'h0000_9234};
      vecs[8]  = '{1'b0, 3'd2, 32'h0000_2004, 32'h0,         32'hCAFE_F00D, 0, 0, 4'b1111, 32'h0,        32'hCAFE_F00D};
      vecs[9]  = '{1'b0, 3'd0, 32'h0000_2001, 32'h0,         32'h0000_7F00, 0, 0, 4'b1111, 32'h0,        32'h0000_007F};
      vecs[10] = '{1'b0, 3'd1, 32'h0000_2001, 32'h0,         32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
      vecs[11] = '{1'b1, 3'd2, 32'h0000_1002, 32'h1,         32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
      vecs[12] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
      vecs[13] = '{1'b1, 3'd4, 32'h0000_0000, 32'h0,         32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};
      vecs[14] = '{1'b0, 3'd2, 32'h0000_3003, 32'h0,         32'h0,        0, 1, 4'b0000, 32'h0,        32'h0};

      repeat (3) @(negedge clk);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_req", {31'b0, dmem_req}, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_be", {28'b0, dmem_be}, 32'd0);
      check("rst_ld_valid", {31'b0, ld_valid}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_stall", {31'b0, stall}, 32'd0);
      check("idle_req", {31'b0, dmem_req}, 32'd0);

      for (int i = 0; i < 15; i++) txn(vecs[i], 5'(i + 1));

      // Back-to-back SW then LW with immediate grants.
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h1000; req_wdata = 32'h1111_2222;
      req_rd = 5'd0; req_valid = 1'b1;
      #1 check("b2b_st_acc", {31'b0, stall}, 32'd1);
      @(negedge clk);
      check("b2b_st_req", {31'b0, dmem_req}, 32'd1);
      dmem_gnt = 1'b1;
      #1 check("b2b_st_done", {31'b0, stall}, 32'd0);
      @(negedge clk);
      dmem_gnt = 1'b0;
      req_we = 1'b0; req_addr = 32'h1004; req_rd = 5'd9;
      #1;
      check("b2b_ld_acc", {31'b0, stall}, 32'd1);
      check("b2b_gap", {31'b0, dmem_req}, 32'd0);
      @(negedge clk);
      check("b2b_ld_req", {31'b0, dmem_req}, 32'd1);
      check("b2b_ld_we", {31'b0, dmem_we}, 32'd0);
      check("b2b_ld_addr", dmem_addr, 32'h1004);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0; req_valid = 1'b0;
      check("b2b_wait", {31'b0, dmem_req}, 32'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_F00D;
      exp_q.push_back('{32'h0BAD_F00D, 5'd9});
      #1 check("b2b_rv_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1 check("b2b_no_dup", {31'b0, dmem_req}, 32'd0);
      @(negedge clk);
      check("b2b_no_dup2", {31'b0, dmem_req}, 32'd0);

      // Reset while waiting for load data; the late rvalid must be dropped.
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h2000; req_rd = 5'd3; req_valid = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0; req_valid = 1'b0;
      #1 check("wait_pre_rst", {31'b0, stall}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_stall", {31'b0, stall}, 32'd0);
      check("mid_rst_req", {31'b0, dmem_req}, 32'd0);
      check("mid_rst_be", {28'b0, dmem_be}, 32'd0);
      check("mid_rst_addr", dmem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
      #1 check("late_rv_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("late_rv_ld", {31'b0, ld_valid}, 32'd0);
      check("late_rv_req", {31'b0, dmem_req}, 32'd0);
      @(negedge clk);
      check("ld_pending", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: XLEN, 32, data/address width; SHALL equal `XLEN.
REQ-002 Parameter: RAW, 5, register address width; SHALL equal `REG_ADDR_WIDTH.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  EXE presents a load/store.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  in  XLEN  effective address (ALU result).
REQ-009 req_wdata  in  XLEN  store data (rs2).
REQ-010 req_rd  in  RAW  load destination register.
REQ-011 stall  out  1  holds upstream pipeline.
REQ-012 dmem_req, dmem_we  out  1  memory request, write strobe.
REQ-013 dmem_addr  out  XLEN  word-aligned address; dmem_be  out  4  byte enables; dmem_wdata  out  XLEN  lane-placed data.
REQ-014 dmem_gnt, dmem_rvalid  in  1  request accepted, read data valid; dmem_rdata  in  XLEN.
REQ-015 ld_valid  out  1; ld_data  out  XLEN; ld_rd  out  RAW: registered load result for the MEM stage.
REQ-016 err  out  1  registered one-cycle pulse: misaligned access or illegal funct3.

Function
REQ-017 FSM states IDLE, REQ, WAIT; IDLE->REQ on req_valid with legal aligned access; REQ->IDLE on dmem_gnt for stores; REQ->WAIT on dmem_gnt for loads; WAIT->IDLE on dmem_rvalid.
REQ-018 Operation SHALL be captured on IDLE->REQ; dmem_* outputs SHALL be registered from the capture and held stable while dmem_req=1 and dmem_gnt=0.
REQ-019 dmem_req SHALL be 1 exactly in REQ; dmem_addr = {addr[XLEN-1:2],2'b00}.
REQ-020 SB: be = 1<<addr[1:0], byte replicated to all lanes; SH: be = addr[1]?4'b1100:4'b0011, half replicated; SW: be=4'b1111; loads drive be=4'b1111, we=0.
REQ-021 stall SHALL be combinational: 1 when (IDLE and req_valid and access legal) or REQ or WAIT, except 0 in the completing cycle (REQ with gnt for store, WAIT with rvalid for load).
REQ-022 Load result: select lane by captured addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU; ld_data/ld_rd/ld_valid registered, ld_valid one-cycle pulse in the cycle after rvalid.
REQ-023 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or illegal funct3 (load 3,6,7; store >=3): no dmem_req, no stall, err pulse next cycle, FSM stays IDLE.
REQ-024 dmem_rvalid outside WAIT and dmem_gnt outside REQ SHALL be ignored; rvalid coincident with gnt in REQ SHALL be ignored.
REQ-025 req_valid=0 in IDLE: all pulses 0, dmem_req 0, stall 0.
REQ-026 Minimum latency: store 2 cycles (IDLE accept, REQ with gnt); load 3 cycles to rvalid plus 1 to ld_valid.

Reset
REQ-027 rst_n low SHALL force IDLE and zero stall, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ld_valid, ld_data, ld_rd, err, immediately.
REQ-028 Reset mid-transaction SHALL abandon it; any later gnt/rvalid for it ignored.

Structure
REQ-029 funct3 encodings and FSM state enum SHALL live in shared package riscv_pkg alongside existing width constants.
REQ-030 Lane placement/extraction SHALL be one combinational sub-module lsu_align; FSM and registers in lsu.

Verification
REQ-031 SW addr 0x1000 data 0xDEADBEEF, gnt after 2 wait cycles -> dmem_addr 0x1000, be 1111, stall high 3 cycles then low on gnt cycle.
REQ-032 SB addr 0x1003 data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
REQ-033 LB addr 0x2002, rdata 0x12F43456 -> ld_data 0xFFFFFFF4; LBU same -> 0x000000F4; ld_valid 1 cycle after rvalid, ld_rd matches.
REQ-034 LH addr 0x2001 -> err pulse next cycle, no dmem_req, stall 0.
REQ-035 rst_n asserted in WAIT, rvalid after release -> IDLE, ld_valid stays 0.
REQ-036 Back-to-back SW then LW with immediate gnt -> second request issued cycle after store completes, no lost or duplicated request.
